// File: rtl/parking_lot_pkg.sv
// Shared encodings for the parking-lot elevator front end: command types,
// scheduler FSM states and the layout of a queued car request.
package parking_lot_pkg;

  localparam int PLATE_W = 16;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_IN   = 2'b01;
  localparam logic [1:0] CMD_OUT  = 2'b10;
  localparam logic [1:0] CMD_LEAK = 2'b11;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  // One queued car request: direction flag plus BCD plate (17 bits total).
  typedef struct packed {
    logic               isOut;
    logic [PLATE_W-1:0] plate;
  } carReq_t;

endpackage

// File: rtl/request_fifo.sv
// First-word-fall-through FIFO holding pending car requests.
// Pushes while full and pops while empty are silently ignored here; the
// scheduler decides what counts as a dropped request.
module request_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         pushData,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush;
  logic             doPop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign doPush   = push & ~full;
  assign doPop    = pop & ~empty;
  assign headData = mem_q[rdPtr_q];
  assign count    = count_q;

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clock) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy is unchanged on push+pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Front-end sequencer: captures park-in/park-out/leakage requests, buffers
// car requests in a FIFO, and hands commands one at a time to the elevator
// controller, waiting for done (or a timeout) between commands. A pending
// leak always beats the FIFO head but never preempts a command in flight.
module elevator_request_scheduler
  import parking_lot_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PLATE_W-1:0] license_plate,
  input  logic               in_mode,
  input  logic               out_mode,
  input  logic               leakage,
  input  logic [2:0]         leakage_floor,
  output logic               cmd_valid,
  output logic [1:0]         cmd_type,
  output logic [PLATE_W-1:0] cmd_plate,
  output logic [2:0]         cmd_floor,
  input  logic               cmd_ready,
  input  logic               done,
  output logic               busy,
  output logic [3:0]         queue_count,
  output logic               queue_full,
  output logic               drop,
  output logic               timeout
);

  logic [1:0]         state_q, state_d;
  logic               cmdValid_q, cmdValid_d;
  logic [1:0]         cmdType_q, cmdType_d;
  logic [PLATE_W-1:0] cmdPlate_q, cmdPlate_d;
  logic [2:0]         cmdFloor_q, cmdFloor_d;
  logic [7:0]         timer_q, timer_d;
  logic               timeout_q, timeout_d;
  logic               drop_q;
  logic               leakPending_q;
  logic [2:0]         leakFloor_q;

  logic                  carReq, carBad, leakOk, leakTake, dropNow;
  logic                  popEn, fifoFull, fifoEmpty;
  carReq_t               pushData, headData;
  logic [$clog2(DEPTH):0] fifoCount;

  assign carBad   = (in_mode & out_mode) | ((in_mode | out_mode) & (license_plate == '0));
  assign carReq   = (in_mode ^ out_mode) & (license_plate != '0);
  assign leakOk   = leakage & (leakage_floor != 3'd0);
  assign leakTake = (state_q == ST_IDLE) & leakPending_q;
  assign popEn    = (state_q == ST_IDLE) & ~leakPending_q & ~fifoEmpty;
  assign pushData = '{isOut: out_mode, plate: license_plate};
  assign dropNow  = carBad
                  | (carReq & fifoFull)
                  | (leakage & (leakage_floor == 3'd0))
                  | (leakOk & leakPending_q & ~leakTake);

  request_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(carReq_t))
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (carReq),
    .pop      (popEn),
    .pushData (pushData),
    .headData (headData),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Leak register: a new alarm overwrites the floor; a take clears pending
  // unless a fresh alarm lands on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      leakPending_q <= 1'b0;
      leakFloor_q   <= 3'd0;
    end else if (leakOk) begin
      leakPending_q <= 1'b1;
      leakFloor_q   <= leakage_floor;
    end else if (leakTake) begin
      leakPending_q <= 1'b0;
    end
  end

  // Next-state and command-field logic for IDLE -> ISSUE -> WAIT_DONE.
  always_comb begin
    state_d    = state_q;
    cmdValid_d = cmdValid_q;
    cmdType_d  = cmdType_q;
    cmdPlate_d = cmdPlate_q;
    cmdFloor_d = cmdFloor_q;
    timer_d    = timer_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (leakPending_q) begin
          state_d    = ST_ISSUE;
          cmdValid_d = 1'b1;
          cmdType_d  = CMD_LEAK;
          cmdPlate_d = '0;
          cmdFloor_d = leakFloor_q;
        end else if (!fifoEmpty) begin
          state_d    = ST_ISSUE;
          cmdValid_d = 1'b1;
          cmdType_d  = headData.isOut ? CMD_OUT : CMD_IN;
          cmdPlate_d = headData.plate;
          cmdFloor_d = 3'd0;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_d    = ST_WAIT_DONE;
          cmdValid_d = 1'b0;
          timer_d    = 8'd0;
        end
      end
      ST_WAIT_DONE: begin
        if (done || (timer_q == 8'(TIMEOUT - 1))) begin
          state_d    = ST_IDLE;
          cmdValid_d = 1'b0;
          cmdType_d  = CMD_NONE;
          cmdPlate_d = '0;
          cmdFloor_d = 3'd0;
          timeout_d  = ~done;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cmdValid_d = 1'b0;
        cmdType_d  = CMD_NONE;
        cmdPlate_d = '0;
        cmdFloor_d = 3'd0;
      end
    endcase
  end

  // Registered FSM state, command outputs and one-cycle status pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmdValid_q <= 1'b0;
      cmdType_q  <= CMD_NONE;
      cmdPlate_q <= '0;
      cmdFloor_q <= 3'd0;
      timer_q    <= 8'd0;
      timeout_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmdValid_q <= cmdValid_d;
      cmdType_q  <= cmdType_d;
      cmdPlate_q <= cmdPlate_d;
      cmdFloor_q <= cmdFloor_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      drop_q     <= dropNow;
    end
  end

  assign cmd_valid   = cmdValid_q;
  assign cmd_type    = cmdType_q;
  assign cmd_plate   = cmdPlate_q;
  assign cmd_floor   = cmdFloor_q;
  assign busy        = (state_q != ST_IDLE);
  assign queue_count = 4'(fifoCount);
  assign queue_full  = fifoFull;
  assign drop        = drop_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler (DEPTH=4, TIMEOUT=64).
module tb_elevator_request_scheduler;
  import parking_lot_pkg::*;

  logic        clock;
  logic        reset;
  logic [15:0] license_plate;
  logic        in_mode;
  logic        out_mode;
  logic        leakage;
  logic [2:0]  leakage_floor;
  logic        cmd_valid;
  logic [1:0]  cmd_type;
  logic [15:0] cmd_plate;
  logic [2:0]  cmd_floor;
  logic        cmd_ready;
  logic        done;
  logic        busy;
  logic [3:0]  queue_count;
  logic        queue_full;
  logic        drop;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  elevator_request_scheduler #(
    .DEPTH   (4),
    .TIMEOUT (64)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .license_plate (license_plate),
    .in_mode       (in_mode),
    .out_mode      (out_mode),
    .leakage       (leakage),
    .leakage_floor (leakage_floor),
    .cmd_valid     (cmd_valid),
    .cmd_type      (cmd_type),
    .cmd_plate     (cmd_plate),
    .cmd_floor     (cmd_floor),
    .cmd_ready     (cmd_ready),
    .done          (done),
    .busy          (busy),
    .queue_count   (queue_count),
    .queue_full    (queue_full),
    .drop          (drop),
    .timeout       (timeout)
  );

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Present one request for exactly one edge, then return inputs to idle.
  task automatic applyStimulus(input logic inM, input logic outM, input logic [15:0] plate,
                               input logic leak, input logic [2:0] lfloor);
    in_mode       = inM;
    out_mode      = outM;
    license_plate = plate;
    leakage       = leak;
    leakage_floor = lfloor;
    tick();
    in_mode       = 1'b0;
    out_mode      = 1'b0;
    license_plate = 16'h0000;
    leakage       = 1'b0;
    leakage_floor = 3'd0;
  endtask

  // Wait (bounded) for the next command, check it, accept it and complete it.
  task automatic serveCommand(input string tag, input logic [1:0] t, input logic [15:0] p,
                              input logic [2:0] f);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    checkOutput({tag, "_type"},  32'(cmd_type),  32'(t));
    checkOutput({tag, "_plate"}, 32'(cmd_plate), 32'(p));
    checkOutput({tag, "_floor"}, 32'(cmd_floor), 32'(f));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic earlyTimeout;
    logic issuedAfterReset;

    reset = 1'b1;
    license_plate = 16'h0000;
    in_mode = 1'b0;
    out_mode = 1'b0;
    leakage = 1'b0;
    leakage_floor = 3'd0;
    cmd_ready = 1'b0;
    done = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_type",  32'(cmd_type),  32'(CMD_NONE));
    checkOutput("rst_busy",  32'(busy),      32'd0);
    checkOutput("rst_count", 32'(queue_count), 32'd0);
    checkOutput("rst_full",  32'(queue_full), 32'd0);
    checkOutput("rst_drop",  32'(drop),      32'd0);
    reset = 1'b0;
    tick();

    // Single park-in with two-edge latency
    applyStimulus(1'b1, 1'b0, 16'h9423, 1'b0, 3'd0);
    checkOutput("in_count1", 32'(queue_count), 32'd1);
    checkOutput("in_notyet", 32'(cmd_valid), 32'd0);
    tick();
    checkOutput("in_valid", 32'(cmd_valid), 32'd1);
    checkOutput("in_type",  32'(cmd_type),  32'(CMD_IN));
    checkOutput("in_plate", 32'(cmd_plate), 32'h9423);
    checkOutput("in_count0", 32'(queue_count), 32'd0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checkOutput("in_waitvalid", 32'(cmd_valid), 32'd0);
    checkOutput("in_waitbusy",  32'(busy), 32'd1);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("in_donebusy", 32'(busy), 32'd0);
    checkOutput("in_doneplate", 32'(cmd_plate), 32'h0000);
    checkOutput("in_donetype", 32'(cmd_type), 32'(CMD_NONE));

    // Leak beats queued car request
    applyStimulus(1'b1, 1'b0, 16'h8754, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 3'd0);
    checkOutput("pri_count", 32'(queue_count), 32'd1);
    checkOutput("pri_plate1", 32'(cmd_plate), 32'h8754);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 3'd3);
    checkOutput("pri_nopreempt", 32'(cmd_valid), 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    serveCommand("pri_leak", CMD_LEAK, 16'h0000, 3'd3);
    serveCommand("pri_out",  CMD_OUT,  16'h1234, 3'd0);
    checkOutput("pri_empty", 32'(queue_count), 32'd0);

    // Full FIFO with controller stalled in ISSUE
    applyStimulus(1'b1, 1'b0, 16'h2000, 1'b0, 3'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h1000 + 16'(i), 1'b0, 3'd0);
    end
    checkOutput("full_count", 32'(queue_count), 32'd4);
    checkOutput("full_flag",  32'(queue_full),  32'd1);
    checkOutput("full_nodrop", 32'(drop), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h1005, 1'b0, 3'd0);
    checkOutput("full_drop",  32'(drop), 32'd1);
    checkOutput("full_count5", 32'(queue_count), 32'd4);
    tick();
    checkOutput("full_droppulse", 32'(drop), 32'd0);
    serveCommand("full_head", CMD_IN, 16'h2000, 3'd0);
    for (int i = 1; i <= 4; i++) begin
      serveCommand("full_drain", CMD_IN, 16'h1000 + 16'(i), 3'd0);
    end
    checkOutput("full_empty", 32'(queue_count), 32'd0);

    // Illegal requests
    applyStimulus(1'b1, 1'b1, 16'h5555, 1'b0, 3'd0);
    checkOutput("ill_both_drop",  32'(drop), 32'd1);
    checkOutput("ill_both_count", 32'(queue_count), 32'd0);
    tick();
    checkOutput("ill_both_pulse", 32'(drop), 32'd0);
    checkOutput("ill_both_nocmd", 32'(cmd_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 3'd0);
    checkOutput("ill_zero_drop",  32'(drop), 32'd1);
    checkOutput("ill_zero_count", 32'(queue_count), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 3'd0);
    checkOutput("ill_floor0_drop", 32'(drop), 32'd1);
    tick();
    checkOutput("ill_nocmd", 32'(cmd_valid), 32'd0);
    checkOutput("ill_idle",  32'(busy), 32'd0);

    // Timeout after TIMEOUT cycles in WAIT_DONE
    applyStimulus(1'b1, 1'b0, 16'h1111, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 16'h2222, 1'b0, 3'd0);
    checkOutput("to_plate", 32'(cmd_plate), 32'h1111);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    earlyTimeout = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      tick();
      if (timeout !== 1'b0) earlyTimeout = 1'b1;
    end
    checkOutput("to_early", 32'(earlyTimeout), 32'd0);
    checkOutput("to_stillbusy", 32'(busy), 32'd1);
    tick();
    checkOutput("to_pulse", 32'(timeout), 32'd1);
    checkOutput("to_idle",  32'(busy), 32'd0);
    tick();
    checkOutput("to_pulseend", 32'(timeout), 32'd0);
    serveCommand("to_next", CMD_IN, 16'h2222, 3'd0);

    // Asynchronous reset mid-command
    applyStimulus(1'b1, 1'b0, 16'h3001, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 16'h3002, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 16'h3003, 1'b0, 3'd0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checkOutput("mr_busy",  32'(busy), 32'd1);
    checkOutput("mr_count", 32'(queue_count), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("mr_valid", 32'(cmd_valid), 32'd0);
    checkOutput("mr_type",  32'(cmd_type), 32'd0);
    checkOutput("mr_plate", 32'(cmd_plate), 32'd0);
    checkOutput("mr_floor", 32'(cmd_floor), 32'd0);
    checkOutput("mr_busy0", 32'(busy), 32'd0);
    checkOutput("mr_count0", 32'(queue_count), 32'd0);
    checkOutput("mr_full0", 32'(queue_full), 32'd0);
    checkOutput("mr_drop0", 32'(drop), 32'd0);
    checkOutput("mr_timeout0", 32'(timeout), 32'd0);
    tick();
    reset = 1'b0;
    issuedAfterReset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cmd_valid !== 1'b0 || busy !== 1'b0) issuedAfterReset = 1'b1;
    end
    checkOutput("mr_noissue", 32'(issuedAfterReset), 32'd0);
    checkOutput("mr_empty", 32'(queue_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
